alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/diablo_alu_pkg.sv | 49 ++++
 rtl/alu_muldiv_iter.sv | 132 +++++++++++++
 rtl/alu_seq.sv | 124 ++++++++++++
 tb/tb_alu_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diablo_alu_pkg.sv
// +--------------------------------------------------------------------------+
// | diablo_alu_pkg : opcode and FSM state types shared by alu_seq blocks      |
// | Optional feature macro: ALU_SEQ_SIGNED_DIV_EN (signed DIV/REM)            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package diablo_alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11,
    ALU_DIVU = 4'd12,
    ALU_REM  = 4'd13,
    ALU_REMU = 4'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Opcodes routed to the iterative datapath instead of completing in one cycle.
  function automatic logic op_is_iter(input alu_op_e op);
    case (op)
      ALU_MUL, ALU_DIVU, ALU_REMU: return 1'b1;
`ifdef ALU_SEQ_SIGNED_DIV_EN
      ALU_DIV, ALU_REM:            return 1'b1;
`endif
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// +--------------------------------------------------------------------------+
// | alu_muldiv_iter : one-bit-per-cycle shift-add multiply / restoring divide |
// | Optional feature macro: ALU_SEQ_SIGNED_DIV_EN (signed DIV/REM correction) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_muldiv_iter
  import diablo_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int            CW     = $clog2(XLEN);
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic            r_is_mul;
  logic            r_want_rem;
  // MUL: r_acc=partial product, r_y=multiplicand, r_z=multiplier.
  // DIV: r_acc=partial remainder, r_y=dividend shifting out / quotient in, r_z=divisor.
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_y;
  logic [XLEN-1:0] r_z;

  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_y_nxt;
  logic [XLEN-1:0] w_z_nxt;
  logic [XLEN:0]   w_rem_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;

  always_comb begin
    w_rem_shift = {r_acc, r_y[XLEN-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_z});
    if (r_is_mul) begin
      w_acc_nxt = r_z[0] ? (r_acc + r_y) : r_acc;
      w_y_nxt   = r_y << 1;
      w_z_nxt   = r_z >> 1;
    end else begin
      w_acc_nxt = w_ge ? (w_rem_shift[XLEN-1:0] - r_z) : w_rem_shift[XLEN-1:0];
      w_y_nxt   = {r_y[XLEN-2:0], w_ge};
      w_z_nxt   = r_z;
    end
  end

`ifdef ALU_SEQ_SIGNED_DIV_EN
  logic w_signed;
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg_q;
  logic r_neg_r;

  // Divide magnitudes, then restore signs; divide-by-zero keeps the all-ones quotient.
  always_comb begin
    w_signed = (i_op == ALU_DIV) || (i_op == ALU_REM);
    w_neg_a  = w_signed && i_a[XLEN-1];
    w_neg_b  = w_signed && i_b[XLEN-1];
    w_op_a   = w_neg_a ? (-i_a) : i_a;
    w_op_b   = w_neg_b ? (-i_b) : i_b;
    w_quo    = r_neg_q ? (-w_y_nxt) : w_y_nxt;
    w_rem    = r_neg_r ? (-w_acc_nxt) : w_acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_neg_q <= w_signed && (w_neg_a ^ w_neg_b) && (i_b != '0);
      r_neg_r <= w_neg_a;
    end
  end
`else
  always_comb begin
    w_op_a = i_a;
    w_op_b = i_b;
    w_quo  = w_y_nxt;
    w_rem  = w_acc_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_is_mul   <= 1'b0;
      r_want_rem <= 1'b0;
      r_acc      <= '0;
      r_y        <= '0;
      r_z        <= '0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_cnt      <= '0;
      r_is_mul   <= (i_op == ALU_MUL);
      r_want_rem <= (i_op == ALU_REM) || (i_op == ALU_REMU);
      r_acc      <= '0;
      r_y        <= w_op_a;
      r_z        <= w_op_b;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_y   <= w_y_nxt;
      r_z   <= w_z_nxt;
      if (r_cnt == C_LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Result is taken from the final iteration's next-state so the owner can latch it on the same edge.
  assign o_done   = r_busy && (r_cnt == C_LAST);
  assign o_result = r_is_mul ? w_acc_nxt : (r_want_rem ? w_rem : w_quo);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------------+
// | alu_seq : handshaked ALU, single-cycle ops plus iterative MUL/DIV/REM     |
// | Optional feature macro: ALU_SEQ_SIGNED_DIV_EN (signed DIV/REM)            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_seq
  import diablo_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_e         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;
  logic            r_alive;
  logic [XLEN-1:0] r_result;
  logic            r_err;

  logic            w_accept;
  logic            w_iter;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_err;
  logic [SHW-1:0]  w_shamt;

  // r_alive keeps in_ready low until the first edge after reset release.
  assign in_ready   = r_alive && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept   = in_valid && in_ready;
  assign w_iter     = op_is_iter(in_op);
  assign w_shamt    = in_b[SHW-1:0];
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_err    = r_err;

  always_comb begin
    w_alu_result = '0;
    w_alu_err    = 1'b0;
    case (in_op)
      ALU_ADD:  w_alu_result = in_a + in_b;
      ALU_SUB:  w_alu_result = in_a - in_b;
      ALU_AND:  w_alu_result = in_a & in_b;
      ALU_OR:   w_alu_result = in_a | in_b;
      ALU_XOR:  w_alu_result = in_a ^ in_b;
      ALU_SLL:  w_alu_result = in_a << w_shamt;
      ALU_SRL:  w_alu_result = in_a >> w_shamt;
      ALU_SRA:  w_alu_result = $signed(in_a) >>> w_shamt;
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default:  w_alu_err    = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_md_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)       w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
        else if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_result <= w_alu_result;
      r_err    <= w_alu_err;
    end else if ((r_state == ST_BUSY) && w_md_done) begin
      r_result <= w_md_result;
      r_err    <= 1'b0;
    end
  end

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept && w_iter),
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------------+
// | tb_alu_seq : self-checking bench for alu_seq (XLEN=64)                    |
// | Optional feature macro: ALU_SEQ_SIGNED_DIV_EN (signed DIV/REM)            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;
  import diablo_alu_pkg::*;

  localparam int XLEN     = 64;
  localparam int LAT_ITER = XLEN + 1;
  localparam logic [63:0] C_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] C_MINS = 64'h8000_0000_0000_0000;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  alu_op_e     in_op     = ALU_ADD;
  logic [63:0] in_a      = '0;
  logic [63:0] in_b      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_result;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  typedef struct {
    alu_op_e     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        err;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each opcode.
  function automatic void model(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic e, output int lat);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    int                 sh;
    sa  = a;
    sb  = b;
    sh  = int'(b % 64);
    r   = '0;
    e   = 1'b0;
    lat = 1;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = sa >>> sh;
      ALU_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
      ALU_SLTU: r = (a < b) ? 64'd1 : 64'd0;
      ALU_MUL:  begin r = a * b; lat = LAT_ITER; end
      ALU_DIVU: begin r = (b == 0) ? C_ONES : a / b; lat = LAT_ITER; end
      ALU_REMU: begin r = (b == 0) ? a : a % b; lat = LAT_ITER; end
`ifdef ALU_SEQ_SIGNED_DIV_EN
      ALU_DIV: begin
        lat = LAT_ITER;
        if (b == 0) r = C_ONES;
        else if (a == C_MINS && b == C_ONES) r = C_MINS;
        else r = sa / sb;
      end
      ALU_REM: begin
        lat = LAT_ITER;
        if (b == 0) r = a;
        else if (a == C_MINS && b == C_ONES) r = '0;
        else r = sa % sb;
      end
`endif
      default:  e = 1'b1;
    endcase
  endfunction

  // Issue one op, hold out_ready low until the result shows, optionally waving junk requests meanwhile.
  task automatic run_op(input alu_op_e op, input logic [63:0] a, input logic [63:0] b, input bit junk,
                        output logic [63:0] res, output logic err, output int lat, output bit leak);
    int guard;
    @(negedge clk);
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    @(negedge clk);
    lat  = 1;
    leak = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) leak = 1'b1;
      in_valid = junk;
      in_op    = alu_op_e'(4'($urandom_range(0, 15)));
      in_a     = {$urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    res = out_result;
    err = out_err;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [63:0] res;
    logic        err;
    int          lat;
    bit          leak;
    logic [63:0] exp_r;
    logic        exp_e;
    int          exp_l;
    logic [63:0] ta;
    logic [63:0] tb;
    logic [63:0] prev;

    vecs.push_back('{ALU_ADD,  C_ONES, 64'd1, 64'd0, 1'b0, 1});
    vecs.push_back('{ALU_SUB,  64'd0, 64'd1, C_ONES, 1'b0, 1});
    vecs.push_back('{ALU_AND,  64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1});
    vecs.push_back('{ALU_OR,   64'hF0F0, 64'h0F00, 64'hFFF0, 1'b0, 1});
    vecs.push_back('{ALU_XOR,  64'hFFFF, 64'h00FF, 64'hFF00, 1'b0, 1});
    vecs.push_back('{ALU_SLL,  64'd1, 64'd63, C_MINS, 1'b0, 1});
    vecs.push_back('{ALU_SLL,  64'd1, 64'd65, 64'd2, 1'b0, 1});
    vecs.push_back('{ALU_SRL,  C_MINS, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1});
    vecs.push_back('{ALU_SRA,  C_MINS, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1});
    vecs.push_back('{ALU_SLT,  C_ONES, 64'd1, 64'd1, 1'b0, 1});
    vecs.push_back('{ALU_SLTU, C_ONES, 64'd1, 64'd0, 1'b0, 1});
    vecs.push_back('{ALU_MUL,  64'd12345, 64'd678, 64'd8369910, 1'b0, 65});
    vecs.push_back('{ALU_DIVU, 64'd100, 64'd0, C_ONES, 1'b0, 65});
    vecs.push_back('{ALU_REMU, 64'd100, 64'd0, 64'd100, 1'b0, 65});
    vecs.push_back('{ALU_DIVU, 64'd100, 64'd7, 64'd14, 1'b0, 65});
    vecs.push_back('{ALU_REMU, 64'd100, 64'd7, 64'd2, 1'b0, 65});
    vecs.push_back('{alu_op_e'(4'hF), 64'd5, 64'd6, 64'd0, 1'b1, 1});
`ifdef ALU_SEQ_SIGNED_DIV_EN
    vecs.push_back('{ALU_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65});
    vecs.push_back('{ALU_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, C_ONES, 1'b0, 65});
    vecs.push_back('{ALU_DIV,  C_MINS, C_ONES, C_MINS, 1'b0, 65});
    vecs.push_back('{ALU_REM,  C_MINS, C_ONES, 64'd0, 1'b0, 65});
    vecs.push_back('{ALU_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0, C_ONES, 1'b0, 65});
    vecs.push_back('{ALU_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 65});
`else
    vecs.push_back('{ALU_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b1, 1});
    vecs.push_back('{ALU_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b1, 1});
`endif

    // Reset state, and in_ready staying low until the first edge after release.
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 chk("rel_in_ready_post_edge", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, res, err, lat, leak);
      chk($sformatf("vec%0d_res", i), res, vecs[i].res);
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      if (vecs[i].lat > 1) chk($sformatf("vec%0d_busy_ready", i), 64'(leak), 64'd0);
    end

    // Back-to-back single-cycle ops with out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    prev = '0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk($sformatf("tp%0d_valid", k), 64'(out_valid), 64'd1);
        chk($sformatf("tp%0d_res", k), out_result, prev);
      end
      if (k < 8) begin
        chk($sformatf("tp%0d_ready", k), 64'(in_ready), 64'd1);
        ta = {$urandom, $urandom};
        tb = {$urandom, $urandom};
        in_valid = 1'b1;
        in_op    = ALU_ADD;
        in_a     = ta;
        in_b     = tb;
        prev     = ta + tb;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-pressure on an SRA result, then an ADD accepted on the release cycle.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = ALU_SRA;
    in_a     = C_MINS;
    in_b     = 64'd4;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_res", c), out_result, 64'hF800_0000_0000_0000);
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = ALU_ADD;
    in_a      = 64'd7;
    in_b      = 64'd8;
    #1 chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_add_valid", 64'(out_valid), 64'd1);
    chk("bp_add_res", out_result, 64'd15);
    chk("bp_add_err", 64'(out_err), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted part-way through a multiply.
    in_valid = 1'b1;
    in_op    = ALU_MUL;
    in_a     = 64'd99991;
    in_b     = 64'd77773;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_result", out_result, 64'd0);
    chk("mrst_out_err", 64'(out_err), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    run_op(ALU_ADD, 64'd2, 64'd3, 1'b0, res, err, lat, leak);
    chk("mrst_add_res", res, 64'd5);
    chk("mrst_add_lat", 64'(lat), 64'd1);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      alu_op_e rop;
      int      mode;
      rop  = alu_op_e'(4'($urandom_range(0, 15)));
      mode = int'($urandom_range(0, 3));
      ta   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ta = -64'($urandom_range(1, 1000));
      case (mode)
        0:       tb = '0;
        1:       tb = 64'($urandom_range(1, 20));
        2:       tb = -64'($urandom_range(1, 20));
        default: tb = {$urandom, $urandom};
      endcase
      model(rop, ta, tb, exp_r, exp_e, exp_l);
      run_op(rop, ta, tb, 1'b1, res, err, lat, leak);
      chk($sformatf("rnd%0d_op%0d_res", n, rop), res, exp_r);
      chk($sformatf("rnd%0d_op%0d_err", n, rop), 64'(err), 64'(exp_e));
      chk($sformatf("rnd%0d_op%0d_lat", n, rop), 64'(lat), 64'(exp_l));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
